// File: rtl/ppe_pkg.sv
// Shared constants, FSM state encodings and partial-sum packet layout for the PPE tap sequencer.
package ppe_pkg;

  localparam int NUM_INPUTS  = 25;
  localparam int FILTER_SIZE = 5;
  localparam int PSUM_W      = 11;

  localparam logic [3:0] OPC_PSUM = 4'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_READ = 3'd1;
  localparam state_t ST_ACC  = 3'd2;
  localparam state_t ST_SEND = 3'd3;
  localparam state_t ST_FIN  = 3'd4;

  // ps_data = {pos[4:0], 9'b0, psum[10:0]}
  localparam int PS_POS_LSB  = 20;
  localparam int PS_POS_W    = 5;
  localparam int PS_PSUM_LSB = 0;

endpackage

// File: rtl/ppe_rd_port.sv
// One RF read channel: request held until its ack, then ack flag and data held until cleared.
module ppe_rd_port #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              req,
  output logic              got,
  output logic [DATA_W-1:0] data_q
);

  logic flag;

  // got also covers the ack cycle itself so the sequencer can leave READ on the capturing edge
  assign req = enable && !flag;
  assign got = flag || (req && ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag   <= 1'b0;
      data_q <= '0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (req && ack) begin
      flag   <= 1'b1;
      data_q <= rd_data;
    end
  end

endmodule

// File: rtl/ppe_tap_sequencer.sv
// Sequences one PPE convolution row: per output position, walks the filter taps and emits a psum packet.
// Optional build macro PPE_SKIP_ZERO_SPIKE_EN: fetch the weight only when the tap's spike is set.
module ppe_tap_sequencer
  import ppe_pkg::*;
#(
  parameter int         PE_ID       = 0,
  parameter int         NUM_INPUTS  = ppe_pkg::NUM_INPUTS,
  parameter int         FILTER_SIZE = ppe_pkg::FILTER_SIZE,
  parameter int         WEIGHT_W    = 8,
  parameter logic [3:0] DEST_ADDR   = 4'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4:0]          cmd_num_pos,
  output logic                w_rd_req,
  output logic [2:0]          w_rd_addr,
  input  logic                w_rd_ack,
  input  logic [WEIGHT_W-1:0] w_rd_data,
  output logic                i_rd_req,
  output logic [4:0]          i_rd_addr,
  input  logic                i_rd_ack,
  input  logic                i_rd_data,
  output logic                ps_valid,
  input  logic                ps_ready,
  output logic [3:0]          ps_dest,
  output logic [3:0]          ps_opcode,
  output logic [24:0]         ps_data,
  output logic                done
);

  localparam int MAX_POS = NUM_INPUTS - FILTER_SIZE + 1;

  state_t              state;
  logic [4:0]          n_pos;
  logic [4:0]          pos;
  logic [2:0]          tap;
  logic [PSUM_W-1:0]   psum;
  logic                in_read;
  logic                w_en;
  logic                rd_done;
  logic                w_got;
  logic                i_got;
  logic [WEIGHT_W-1:0] w_q;
  logic [0:0]          i_q;

  assign in_read = (state == ST_READ);

`ifdef PPE_SKIP_ZERO_SPIKE_EN
  logic i_val;
  // weight request waits for the registered spike; a zero spike finishes the tap without it
  assign i_val   = (i_rd_req && i_rd_ack) ? i_rd_data : i_q[0];
  assign w_en    = in_read && !i_rd_req && i_q[0];
  assign rd_done = i_got && (!i_val || w_got);
`else
  assign w_en    = in_read;
  assign rd_done = i_got && w_got;
`endif

  ppe_rd_port #(.DATA_W(WEIGHT_W)) u_w_port (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_en),
    .clear   (state == ST_ACC),
    .ack     (w_rd_ack),
    .rd_data (w_rd_data),
    .req     (w_rd_req),
    .got     (w_got),
    .data_q  (w_q)
  );

  ppe_rd_port #(.DATA_W(1)) u_i_port (
    .clk     (clk),
    .reset   (reset),
    .enable  (in_read),
    .clear   (state == ST_ACC),
    .ack     (i_rd_ack),
    .rd_data (i_rd_data),
    .req     (i_rd_req),
    .got     (i_got),
    .data_q  (i_q)
  );

  // Row sequencing; pos/tap/psum return to zero on FIN so idle addresses read as 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      n_pos <= '0;
      pos   <= '0;
      tap   <= '0;
      psum  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            n_pos <= (cmd_num_pos > 5'(MAX_POS)) ? 5'(MAX_POS) : cmd_num_pos;
            pos   <= '0;
            tap   <= '0;
            psum  <= '0;
            state <= (cmd_num_pos == 5'd0) ? ST_FIN : ST_READ;
          end
        end
        ST_READ: begin
          if (rd_done) state <= ST_ACC;
        end
        ST_ACC: begin
          if (i_q[0]) psum <= psum + PSUM_W'(w_q);
          if (tap < 3'(FILTER_SIZE - 1)) begin
            tap   <= tap + 3'd1;
            state <= ST_READ;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ps_ready) begin
            if (pos == n_pos - 5'd1) begin
              state <= ST_FIN;
            end else begin
              pos   <= pos + 5'd1;
              tap   <= '0;
              psum  <= '0;
              state <= ST_READ;
            end
          end
        end
        ST_FIN: begin
          pos   <= '0;
          tap   <= '0;
          psum  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign done      = (state == ST_FIN);
  assign ps_valid  = (state == ST_SEND);
  assign w_rd_addr = tap;
  assign i_rd_addr = pos + 5'(tap);
  assign ps_dest   = ps_valid ? DEST_ADDR : 4'd0;
  assign ps_opcode = ps_valid ? OPC_PSUM : 4'd0;

  always_comb begin
    ps_data = '0;
    if (ps_valid) begin
      ps_data[PS_POS_LSB +: PS_POS_W]  = pos;
      ps_data[PS_PSUM_LSB +: PSUM_W]   = psum;
    end
  end

endmodule

// File: tb/tb_ppe_tap_sequencer.sv
// Scoreboard bench for ppe_tap_sequencer: directed rows, RF ack-skew models, stall and reset abort.
module tb_ppe_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_num_pos = '0;
  logic        w_rd_req;
  logic [2:0]  w_rd_addr;
  logic        w_rd_ack = 1'b0;
  logic [7:0]  w_rd_data = '0;
  logic        i_rd_req;
  logic [4:0]  i_rd_addr;
  logic        i_rd_ack = 1'b0;
  logic        i_rd_data = 1'b0;
  logic        ps_valid;
  logic        ps_ready = 1'b1;
  logic [3:0]  ps_dest;
  logic [3:0]  ps_opcode;
  logic [24:0] ps_data;
  logic        done;

  ppe_tap_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_num_pos (cmd_num_pos),
    .w_rd_req    (w_rd_req),
    .w_rd_addr   (w_rd_addr),
    .w_rd_ack    (w_rd_ack),
    .w_rd_data   (w_rd_data),
    .i_rd_req    (i_rd_req),
    .i_rd_addr   (i_rd_addr),
    .i_rd_ack    (i_rd_ack),
    .i_rd_data   (i_rd_data),
    .ps_valid    (ps_valid),
    .ps_ready    (ps_ready),
    .ps_dest     (ps_dest),
    .ps_opcode   (ps_opcode),
    .ps_data     (ps_data),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  weights[8];
  logic [31:0] spikes = '0;
  int          w_delay = 1;
  int          i_delay = 1;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int   pkt_count = 0;
  int   done_count = 0;
  int   req_seen = 0;
  int   w_pulses = 0;
  int   max_i_addr = 0;
  int   first_valid_cnt = 0;
  int   last_acc_cnt = 0;
  int   done_at = 0;
  int   accept_cnt = 0;
  logic armed = 1'b0;
  logic w_req_prev = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [32:0] exp_pkt(input int p, input int s);
    return {4'd0, 4'd3, 5'(p), 9'd0, 11'(s)};
  endfunction

  // Weight RF: ack w_delay negedges after the request is first seen, held one cycle
  initial forever begin
    @(negedge clk);
    if (w_rd_req === 1'b1 && !reset) begin
      repeat (w_delay) @(negedge clk);
      w_rd_data = weights[w_rd_addr];
      w_rd_ack  = 1'b1;
      @(negedge clk);
      w_rd_ack  = 1'b0;
      w_rd_data = '0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (i_rd_req === 1'b1 && !reset) begin
      repeat (i_delay) @(negedge clk);
      i_rd_data = spikes[i_rd_addr];
      i_rd_ack  = 1'b1;
      @(negedge clk);
      i_rd_ack  = 1'b0;
      i_rd_data = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever a packet is accepted, tracks reads and done
  always @(negedge clk) begin
    if (!reset) begin
      if (i_rd_req || w_rd_req) req_seen++;
      if (i_rd_req && int'(i_rd_addr) > max_i_addr) max_i_addr = int'(i_rd_addr);
      if (w_rd_req && !w_req_prev) w_pulses++;
      if (ps_valid && armed) begin
        first_valid_cnt = cycle_cnt;
        armed = 1'b0;
      end
      if (ps_valid && ps_ready) begin
        pkt_count++;
        last_acc_cnt = cycle_cnt;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_packet actual=%0h required=none", {ps_dest, ps_opcode, ps_data});
        end else begin
          check_output("packet", 64'({ps_dest, ps_opcode, ps_data}), 64'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_count++;
        done_at = cycle_cnt;
      end
    end
    w_req_prev = w_rd_req;
  end

  task automatic reset_stats;
    pkt_count  = 0;
    done_count = 0;
    req_seen   = 0;
    w_pulses   = 0;
    max_i_addr = 0;
    armed      = 1'b1;
  endtask

  task automatic wait_idle;
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 2000);
    if (!cmd_ready) check_output("idle_timeout", 64'(cmd_ready), 64'd1);
  endtask

  // Issue one command; accept_cnt is the cycle count just after the accepting edge
  task automatic apply_stimulus(input logic [4:0] n);
    @(posedge clk);
    #1 cmd_valid = 1'b1;
    cmd_num_pos = n;
    @(posedge clk);
    #1 accept_cnt = cycle_cnt;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < limit);
    if (!done) check_output("done_timeout", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic finish_case(input string name, input int n_pkts);
    check_output({name, "_pkts"}, 64'(pkt_count), 64'(n_pkts));
    check_output({name, "_done"}, 64'(done_count), 64'd1);
    check_output({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic set_weights(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [7:0] w3, input logic [7:0] w4);
    weights[0] = w0; weights[1] = w1; weights[2] = w2; weights[3] = w3; weights[4] = w4;
    for (int i = 5; i < 8; i++) weights[i] = 8'h00;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   skew_w[3] = '{4, 1, 1};
    int   skew_i[3] = '{1, 4, 1};
    logic stable;
    int   stall_reqs;
    int   k;
    logic [32:0] snap;

    set_weights(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs",
                 64'({w_rd_req, i_rd_req, w_rd_addr, i_rd_addr, ps_valid, ps_dest, ps_opcode, ps_data, done}), 64'd0);
    check_output("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;

    // One position, spikes on taps 0,2,4 with weight 10: 30
    wait_idle();
    set_weights(8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
    spikes = 32'b10101;
    reset_stats();
    exp_q.push_back(exp_pkt(0, 30));
    apply_stimulus(5'd1);
    wait_done(200);
    finish_case("single", 1);
`ifndef PPE_SKIP_ZERO_SPIKE_EN
    check_output("first_valid_latency", 64'(first_valid_cnt - accept_cnt), 64'd15);
`endif
    check_output("single_done_latency", 64'(done_at - last_acc_cnt), 64'd1);

    // Full row at maximum weights: 5*255 = 1275 per position
    wait_idle();
    set_weights(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    spikes = 32'h01FF_FFFF;
    reset_stats();
    for (int p = 0; p < 21; p++) exp_q.push_back(exp_pkt(p, 1275));
    apply_stimulus(5'd21);
    wait_done(1000);
    finish_case("full_row", 21);
    check_output("max_i_addr", 64'(max_i_addr), 64'd24);
    check_output("full_done_latency", 64'(done_at - last_acc_cnt), 64'd1);

    // Zero positions: done in the first cycle after accept, no reads
    wait_idle();
    reset_stats();
    apply_stimulus(5'd0);
    wait_done(20);
    finish_case("zero_pos", 0);
    check_output("zero_pos_reads", 64'(req_seen), 64'd0);
    check_output("zero_pos_done_latency", 64'(done_at - accept_cnt), 64'd0);

    // Oversized request clamps to 21 positions
    wait_idle();
    set_weights(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
    reset_stats();
    for (int p = 0; p < 21; p++) exp_q.push_back(exp_pkt(p, 5));
    apply_stimulus(5'd31);
    wait_done(1000);
    finish_case("clamp", 21);

    // Ack skew: pos0 taps {1,0,1,1,0}=13, pos1 taps {0,1,1,0,1}=22 with weights 1,2,4,8,16
    set_weights(8'd1, 8'd2, 8'd4, 8'd8, 8'd16);
    spikes = 32'b101101;
    for (int s = 0; s < 3; s++) begin
      wait_idle();
      w_delay = skew_w[s];
      i_delay = skew_i[s];
      reset_stats();
      exp_q.push_back(exp_pkt(0, 13));
      exp_q.push_back(exp_pkt(1, 22));
      apply_stimulus(5'd2);
      wait_done(400);
      finish_case("skew", 2);
    end

    // Backpressure: hold ps_ready low for 10 cycles once the first packet is offered
    wait_idle();
    w_delay = 1;
    i_delay = 1;
    ps_ready = 1'b0;
    reset_stats();
    exp_q.push_back(exp_pkt(0, 13));
    exp_q.push_back(exp_pkt(1, 22));
    apply_stimulus(5'd2);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ps_valid && k < 100);
    check_output("stall_valid_seen", 64'(ps_valid), 64'd1);
    snap = {ps_dest, ps_opcode, ps_data};
    stable = 1'b1;
    stall_reqs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!ps_valid || {ps_dest, ps_opcode, ps_data} !== snap) stable = 1'b0;
      if (w_rd_req || i_rd_req) stall_reqs++;
    end
    check_output("stall_stable", 64'(stable), 64'd1);
    check_output("stall_no_reads", 64'(stall_reqs), 64'd0);
    @(posedge clk);
    #1 ps_ready = 1'b1;
    wait_done(400);
    finish_case("stall", 2);

    // Reset while reading: silent abort
    wait_idle();
    reset_stats();
    apply_stimulus(5'd3);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!i_rd_req && k < 20);
    check_output("abort_in_read", 64'(i_rd_req), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_output("abort_outputs",
                 64'({w_rd_req, i_rd_req, w_rd_addr, i_rd_addr, ps_valid, ps_dest, ps_opcode, ps_data, done}), 64'd0);
    check_output("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    check_output("abort_no_done", 64'(done_count), 64'd0);
    check_output("abort_no_pkts", 64'(pkt_count), 64'd0);

`ifdef PPE_SKIP_ZERO_SPIKE_EN
    // No spikes: weights are never fetched and every psum is zero
    wait_idle();
    set_weights(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    spikes = '0;
    reset_stats();
    exp_q.push_back(exp_pkt(0, 0));
    exp_q.push_back(exp_pkt(1, 0));
    apply_stimulus(5'd2);
    wait_done(400);
    finish_case("skip_zero", 2);
    check_output("skip_w_pulses", 64'(w_pulses), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
